// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_if
// Brief    : Operand/result handshake bundle for pipelined_adder.
// Revision : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_Valid;
    logic             o_Ready;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic             i_Cin;
    logic             i_Sub;
    logic             o_Valid;
    logic             i_Ready;
    logic [WIDTH-1:0] o_Sum;
    logic             o_Cout;
    logic             o_Ovf;

    modport slave (
        input  i_Valid, i_A, i_B, i_Cin, i_Sub, i_Ready,
        output o_Ready, o_Valid, o_Sum, o_Cout, o_Ovf
    );

    modport master (
        output i_Valid, i_A, i_B, i_Cin, i_Sub, i_Ready,
        input  o_Ready, o_Valid, o_Sum, o_Cout, o_Ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Brief    : Add/subtract unit split into WIDTH/CHUNK carry-pipelined stages.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Inputs seen by each stage: stage 0 from the bus, others from stage k-1
    logic [WIDTH-1:0] w_a_in [STAGES];
    logic [WIDTH-1:0] w_b_in [STAGES];
    logic [WIDTH-1:0] w_s_in [STAGES];
    logic             w_c_in [STAGES];
    logic             w_v_in [STAGES];

    assign w_adv       = !bus.o_Valid || bus.i_Ready;
    assign bus.o_Ready = w_adv;

    assign w_b_eff = bus.i_Sub ? ~bus.i_B : bus.i_B;
    assign w_c0    = bus.i_Sub | bus.i_Cin;

    assign w_a_in[0] = bus.i_A;
    assign w_b_in[0] = w_b_eff;
    assign w_s_in[0] = '0;
    assign w_c_in[0] = w_c0;
    assign w_v_in[0] = bus.i_Valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK:0]   w_chunk;
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_s;

        assign w_chunk = {1'b0, w_a_in[k][CHUNK-1:0]}
                       + {1'b0, w_b_in[k][CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, w_c_in[k]};

        // Sum chunks enter at the top and shift down, so after the last stage
        // chunk 0 sits at bit 0.
        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_adv) begin
                r_v <= w_v_in[k];
                r_c <= w_chunk[CHUNK];
                r_s <= (w_s_in[k] >> CHUNK)
                     | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= (w_a_in[k][CHUNK-1] == w_b_in[k][CHUNK-1])
                          && (w_chunk[CHUNK-1] != w_a_in[k][CHUNK-1]);
                end
            end

            assign bus.o_Valid = r_v;
            assign bus.o_Sum   = r_s;
            assign bus.o_Cout  = r_c;
            assign bus.o_Ovf   = r_ovf;
        end else begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            // Operands shift right as they are consumed; chunk k+1 lands at bit 0
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[k] >> CHUNK;
                    r_b <= w_b_in[k] >> CHUNK;
                end
            end

            assign w_a_in[k+1] = r_a;
            assign w_b_in[k+1] = r_b;
            assign w_s_in[k+1] = r_s;
            assign w_c_in[k+1] = r_c;
            assign w_v_in[k+1] = r_v;
        end
    end
endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4: bits added per pipeline stage; SHALL divide WIDTH exactly; STAGES = WIDTH/CHUNK.
REQ-003 i_Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_Rst  input  1  reset, asynchronous, active-high.
REQ-005 i_Valid  input  1  operands present this cycle.
REQ-006 o_Ready  output  1  block accepts operands this cycle.
REQ-007 i_A, i_B  input  WIDTH  operands.
REQ-008 i_Cin  input  1  carry-in; used in add mode only.
REQ-009 i_Sub  input  1  0 = add, 1 = subtract.
REQ-010 o_Valid  output  1  result present.
REQ-011 i_Ready  input  1  downstream accepts result.
REQ-012 o_Sum  output  WIDTH  result.
REQ-013 o_Cout  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-014 o_Ovf  output  1  signed two's-complement overflow.

Function
REQ-015 Effective operands SHALL be: add -> B' = i_B, c0 = i_Cin; subtract -> B' = ~i_B, c0 = 1 (i_Cin ignored).
REQ-016 Result SHALL equal {o_Cout, o_Sum} = i_A + B' + c0, computed modulo 2^(WIDTH+1).
REQ-017 o_Ovf SHALL be 1 iff i_A[MSB] == B'[MSB] and o_Sum[MSB] != i_A[MSB].
REQ-018 Stage k (0..STAGES-1) SHALL add chunk k of A and B' plus the carry registered from stage k-1 (c0 for stage 0) and register its sum chunk and carry-out.
REQ-019 Unprocessed upper operand chunks and completed lower sum chunks SHALL be carried forward in per-stage registers alongside a per-stage valid bit.
REQ-020 Transfer in SHALL occur when i_Valid && o_Ready; transfer out when o_Valid && i_Ready.
REQ-021 Pipe advance = !o_Valid || i_Ready; o_Ready SHALL equal advance (combinational from o_Valid and i_Ready only).
REQ-022 On advance, every stage SHALL shift one place; stage-0 valid loads i_Valid; on no advance, all stage registers and valid bits SHALL hold.
REQ-023 Latency SHALL be exactly STAGES cycles from accepted input to o_Valid when not stalled; throughput one operation per cycle.
REQ-024 Bubbles (i_Valid = 0 on advance) SHALL propagate as invalid slots; they are not compressed.
REQ-025 While o_Valid && !i_Ready, o_Sum, o_Cout, o_Ovf SHALL stay stable and o_Ready SHALL be 0.
REQ-026 Outputs SHALL come directly from final-stage registers; o_Sum/o_Cout/o_Ovf are don't-care when o_Valid = 0 but SHALL never be X after reset.
REQ-027 STAGES = 1 (CHUNK = WIDTH) SHALL yield a single registered adder with latency 1.
REQ-028 Simultaneous accept and emit in the same cycle SHALL lose no data.

Reset
REQ-029 i_Rst high SHALL immediately clear all valid bits, o_Valid, o_Sum, o_Cout, o_Ovf to 0, independent of i_Clk.
REQ-030 In-flight operations at reset SHALL be discarded; none SHALL emerge after release.
REQ-031 o_Ready SHALL be 1 during and after reset (o_Valid = 0).
REQ-032 First acceptance SHALL be possible on the first rising edge with i_Rst low.

Verification (WIDTH=8, CHUNK=4, i_Ready=1 unless stated)
REQ-033 Add 0xFF + 0x01, i_Cin=0 -> 2 cycles later o_Valid=1, o_Sum=0x00, o_Cout=1, o_Ovf=0; also 0x7F + 0x01 -> 0x80, o_Cout=0, o_Ovf=1.
REQ-034 Subtract 0x05 - 0x07 -> 0xFE, o_Cout=0, o_Ovf=0; 0x80 - 0x01 -> 0x7F, o_Cout=1, o_Ovf=1; i_Cin=1 during subtract has no effect.
REQ-035 Three back-to-back ops (0x10+0x01, 0x20+0x02, 0x30+0x03) -> o_Valid high three consecutive cycles with 0x11, 0x22, 0x33 in order.
REQ-036 Result valid, i_Ready=0 for 4 cycles with i_Valid=1 -> o_Ready=0, outputs frozen, no input accepted; i_Ready=1 -> pipe resumes, no loss or duplication.
REQ-037 Assert i_Rst one cycle after accepting 0x12+0x34 -> outputs and o_Valid go to 0 asynchronously; after release no result emerges without new input.
REQ-038 Randomised 10k ops with random i_Valid/i_Ready and CHUNK in {1,2,4,8} -> every result matches reference model, in order, no drops.
